// File: rtl/controle_escrita_registradores_if.sv
// Interface for the write-back queue: producer request handshake,
// bank write port, pending-write lookup and queue status.
// master = execution side / environment, slave = the queue itself.
interface controle_escrita_registradores_if #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA_DADO = 32,
    parameter int LARGURA_END  = 5
);
    localparam int LARGURA_OCUP = $clog2(PROFUNDIDADE) + 1;

    // request handshake
    logic                    pedido_valido;
    logic                    pedido_pronto;
    logic [LARGURA_END-1:0]  pedido_endereco;
    logic [LARGURA_DADO-1:0] pedido_dado;

    // bank write port
    logic                    habilita_drenagem;
    logic                    uc_escrita;
    logic [LARGURA_END-1:0]  endereco_escrita;
    logic [LARGURA_DADO-1:0] dado_p_escrita;

    // pending-write lookup
    logic [LARGURA_END-1:0]  endereco_leitura_1;
    logic [LARGURA_END-1:0]  endereco_leitura_2;
    logic                    encaminha_1;
    logic                    encaminha_2;
    logic [LARGURA_DADO-1:0] dado_encaminhado_1;
    logic [LARGURA_DADO-1:0] dado_encaminhado_2;

    // status
    logic                    vazia;
    logic [LARGURA_OCUP-1:0] ocupacao;

    modport master (
        output pedido_valido, pedido_endereco, pedido_dado,
        output habilita_drenagem, endereco_leitura_1, endereco_leitura_2,
        input  pedido_pronto, uc_escrita, endereco_escrita, dado_p_escrita,
        input  encaminha_1, encaminha_2, dado_encaminhado_1, dado_encaminhado_2,
        input  vazia, ocupacao
    );

    modport slave (
        input  pedido_valido, pedido_endereco, pedido_dado,
        input  habilita_drenagem, endereco_leitura_1, endereco_leitura_2,
        output pedido_pronto, uc_escrita, endereco_escrita, dado_p_escrita,
        output encaminha_1, encaminha_2, dado_encaminhado_1, dado_encaminhado_2,
        output vazia, ocupacao
    );
endinterface

// File: rtl/controle_escrita_registradores.sv
// Write-back queue feeding the 32x32 register bank write port.
// Requests are buffered in a circular FIFO and drained one per cycle
// through a registered bank write port. Writes to register 0 complete
// the handshake but are discarded.
// Optional macro ENCAMINHAMENTO_EN builds the pending-write lookup used
// by the read side for bypass; without it the lookup outputs are 0.
module controle_escrita_registradores #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA_DADO = 32,
    parameter int LARGURA_END  = 5
) (
    input logic clock,
    input logic reset,
    controle_escrita_registradores_if.slave bus
);
    localparam int LARGURA_PTR  = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int LARGURA_OCUP = $clog2(PROFUNDIDADE) + 1;

    // storage is not reset: ocupacao alone defines which slots are live
    logic [LARGURA_END-1:0]  mem_end  [PROFUNDIDADE];
    logic [LARGURA_DADO-1:0] mem_dado [PROFUNDIDADE];

    logic [LARGURA_PTR-1:0]  ptr_leitura;
    logic [LARGURA_PTR-1:0]  ptr_escrita;
    logic [LARGURA_OCUP-1:0] ocupacao_q;

    logic                    uc_q;
    logic [LARGURA_END-1:0]  end_q;
    logic [LARGURA_DADO-1:0] dado_q;

    logic cheia;
    logic vazia_i;
    logic aceita;
    logic grava;
    logic drena;

    // ready depends only on occupancy: a pop in the same cycle does not
    // make room for a push into a full queue
    assign cheia   = (ocupacao_q == LARGURA_OCUP'(PROFUNDIDADE));
    assign vazia_i = (ocupacao_q == '0);
    assign aceita  = bus.pedido_valido && !cheia;
    // register 0 is hard-wired; accept the request but store nothing
    assign grava   = aceita && (bus.pedido_endereco != '0);
    assign drena   = !vazia_i && bus.habilita_drenagem;

    // FIFO storage write at the tail
    always_ff @(posedge clock) begin
        if (grava) begin
            mem_end[ptr_escrita]  <= bus.pedido_endereco;
            mem_dado[ptr_escrita] <= bus.pedido_dado;
        end
    end

    // pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_leitura <= '0;
            ptr_escrita <= '0;
            ocupacao_q  <= '0;
        end else begin
            if (grava)
                ptr_escrita <= ptr_escrita + 1'b1;
            if (drena)
                ptr_leitura <= ptr_leitura + 1'b1;
            case ({grava, drena})
                2'b10:   ocupacao_q <= ocupacao_q + 1'b1;
                2'b01:   ocupacao_q <= ocupacao_q - 1'b1;
                default: ocupacao_q <= ocupacao_q;
            endcase
        end
    end

    // registered bank write port: one-cycle strobe, address/data hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uc_q   <= 1'b0;
            end_q  <= '0;
            dado_q <= '0;
        end else if (drena) begin
            uc_q   <= 1'b1;
            end_q  <= mem_end[ptr_leitura];
            dado_q <= mem_dado[ptr_leitura];
        end else begin
            uc_q   <= 1'b0;
        end
    end

    assign bus.pedido_pronto    = !cheia;
    assign bus.vazia            = vazia_i;
    assign bus.ocupacao         = ocupacao_q;
    assign bus.uc_escrita       = uc_q;
    assign bus.endereco_escrita = end_q;
    assign bus.dado_p_escrita   = dado_q;

`ifdef ENCAMINHAMENTO_EN
    typedef struct packed {
        logic                    achou;
        logic [LARGURA_DADO-1:0] dado;
    } busca_t;

    // Scan from oldest to newest so the last hit is the youngest write.
    // The output register is older than every queued entry, so it seeds
    // the search.
    function automatic busca_t procura(input logic [LARGURA_END-1:0] alvo);
        busca_t                 r;
        logic [LARGURA_PTR-1:0] idx;
        r = '0;
        if (alvo != '0) begin
            if (uc_q && (end_q == alvo)) begin
                r.achou = 1'b1;
                r.dado  = dado_q;
            end
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                idx = ptr_leitura + LARGURA_PTR'(i);
                if ((LARGURA_OCUP'(i) < ocupacao_q) && (mem_end[idx] == alvo)) begin
                    r.achou = 1'b1;
                    r.dado  = mem_dado[idx];
                end
            end
        end
        return r;
    endfunction

    busca_t busca_1;
    busca_t busca_2;

    // pending-write lookup for both read ports
    always_comb begin
        busca_1 = procura(bus.endereco_leitura_1);
        busca_2 = procura(bus.endereco_leitura_2);
    end

    assign bus.encaminha_1        = busca_1.achou;
    assign bus.dado_encaminhado_1 = busca_1.dado;
    assign bus.encaminha_2        = busca_2.achou;
    assign bus.dado_encaminhado_2 = busca_2.dado;
`else
    // no bypass: read side stalls on !vazia instead
    logic unused_leitura;
    assign unused_leitura = ^{bus.endereco_leitura_1, bus.endereco_leitura_2};

    assign bus.encaminha_1        = 1'b0;
    assign bus.dado_encaminhado_1 = '0;
    assign bus.encaminha_2        = 1'b0;
    assign bus.dado_encaminhado_2 = '0;
`endif

endmodule
